// File: rtl/rob_commit.sv
// rob_commit: in-order commit end of register renaming.
// Records allocations at the tail and marks out-of-order completions as done.
// Retires one entry per cycle from the head, in program order, and returns
// the superseded physical register to the free list.
// Retire path: the decision is registered into stage 1, then into the
// output stage, so retire_valid rises two edges after the done bit is set.
module rob_commit #(
  parameter int DEPTH  = 16,
  parameter int ROB_W  = 4,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic              alloc_regwrite,
  input  logic [AREG_W-1:0] alloc_dr,
  input  logic [PREG_W-1:0] alloc_dr_p,
  input  logic [PREG_W-1:0] alloc_old_p,
  output logic              alloc_ready,
  output logic [ROB_W-1:0]  alloc_rob_num,
  input  logic              cmpl_valid,
  input  logic [ROB_W-1:0]  cmpl_rob_num,
  output logic              retire_valid,
  output logic [ROB_W-1:0]  retire_rob_num,
  output logic [AREG_W-1:0] retire_dr,
  output logic [PREG_W-1:0] retire_dr_p,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_p,
  output logic [ROB_W:0]    count,
  output logic              empty,
  output logic              full
);

  localparam logic [ROB_W:0] DEPTH_C = DEPTH[ROB_W:0];

  typedef struct packed {
    logic              rw;
    logic [AREG_W-1:0] dr;
    logic [PREG_W-1:0] drP;
    logic [PREG_W-1:0] oldP;
  } robEnt_t;

  logic [DEPTH-1:0] entValid, entDone;
  robEnt_t          ent [DEPTH];
  logic [ROB_W-1:0] head, tail;

  logic             s1Vld;
  logic [ROB_W-1:0] s1Tag;
  robEnt_t          s1Ent;

  logic allocFire, retFire;

  assign full          = (count == DEPTH_C);
  assign empty         = (count == '0);
  assign alloc_ready   = ~full;
  assign alloc_rob_num = tail;
  assign allocFire     = alloc_valid & alloc_ready;
  // Uses the pre-edge done bit: a completion to the head this cycle retires next cycle.
  assign retFire       = entValid[head] & entDone[head];

  // Entry payload is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (allocFire)
      ent[tail] <= '{rw: alloc_regwrite, dr: alloc_dr, drP: alloc_dr_p, oldP: alloc_old_p};
  end

  // Occupancy, completion marking, head/tail pointers and the two retire stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      entValid       <= '0;
      entDone        <= '0;
      s1Vld          <= 1'b0;
      s1Tag          <= '0;
      s1Ent          <= '0;
      retire_valid   <= 1'b0;
      retire_rob_num <= '0;
      retire_dr      <= '0;
      retire_dr_p    <= '0;
      free_valid     <= 1'b0;
      free_p         <= '0;
    end else begin
      // Completion to an invalid slot is dropped; repeats are harmless.
      if (cmpl_valid && entValid[cmpl_rob_num])
        entDone[cmpl_rob_num] <= 1'b1;
      // Retire clear comes after completion so a repeat completion cannot revive the head.
      if (retFire) begin
        entValid[head] <= 1'b0;
        entDone[head]  <= 1'b0;
        head           <= head + 1'b1;
      end
      // Alloc cannot hit the retiring slot: that would require full, which blocks alloc.
      if (allocFire) begin
        entValid[tail] <= 1'b1;
        entDone[tail]  <= 1'b0;
        tail           <= tail + 1'b1;
      end
      case ({allocFire, retFire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      s1Vld <= retFire;
      if (retFire) begin
        s1Tag <= head;
        s1Ent <= ent[head];
      end

      retire_valid <= s1Vld;
      free_valid   <= s1Vld & s1Ent.rw & (s1Ent.oldP != '0);
      if (s1Vld) begin
        retire_rob_num <= s1Tag;
        retire_dr      <= s1Ent.dr;
        retire_dr_p    <= s1Ent.drP;
        free_p         <= s1Ent.oldP;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: reset state, single retire latency,
// out-of-order completion, full/wrap, free suppression, steady stream + reset.
module tb_rob_commit;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid, alloc_regwrite;
  logic [4:0] alloc_dr;
  logic [5:0] alloc_dr_p, alloc_old_p;
  logic       alloc_ready;
  logic [3:0] alloc_rob_num;
  logic       cmpl_valid;
  logic [3:0] cmpl_rob_num;
  logic       retire_valid;
  logic [3:0] retire_rob_num;
  logic [4:0] retire_dr;
  logic [5:0] retire_dr_p;
  logic       free_valid;
  logic [5:0] free_p;
  logic [4:0] count;
  logic       empty, full;

  int         nChk = 0;
  int         nErr = 0;
  int         retCnt = 0;
  logic [3:0] expRetTag = '0;

  always #5 clk = ~clk;

  rob_commit #(.DEPTH(16), .ROB_W(4), .AREG_W(5), .PREG_W(6)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_regwrite(alloc_regwrite),
    .alloc_dr(alloc_dr), .alloc_dr_p(alloc_dr_p), .alloc_old_p(alloc_old_p),
    .alloc_ready(alloc_ready), .alloc_rob_num(alloc_rob_num),
    .cmpl_valid(cmpl_valid), .cmpl_rob_num(cmpl_rob_num),
    .retire_valid(retire_valid), .retire_rob_num(retire_rob_num),
    .retire_dr(retire_dr), .retire_dr_p(retire_dr_p),
    .free_valid(free_valid), .free_p(free_p),
    .count(count), .empty(empty), .full(full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_regwrite = 0; alloc_dr = '0; alloc_dr_p = '0; alloc_old_p = '0;
    cmpl_valid = 0; cmpl_rob_num = '0;
  endtask

  task automatic doReset();
    idle();
    rst = 1; tick(); tick();
    rst = 0;
    expRetTag = '0;
  endtask

  task automatic alloc(input logic rw, input logic [4:0] dr, input logic [5:0] drp, input logic [5:0] oldp);
    alloc_valid = 1; alloc_regwrite = rw; alloc_dr = dr; alloc_dr_p = drp; alloc_old_p = oldp;
  endtask

  task automatic cmpl(input logic [3:0] tag);
    cmpl_valid = 1; cmpl_rob_num = tag;
  endtask

  // Every retire must carry the next tag in program order.
  always @(negedge clk) begin
    if (retire_valid) begin
      chk("retOrder", retire_rob_num, expRetTag);
      expRetTag = expRetTag + 1'b1;
      retCnt++;
    end
  end

  initial begin
    // 1: reset state
    idle();
    rst = 1; tick(); tick();
    chk("rstEmpty", empty, 1);
    chk("rstCount", count, 0);
    chk("rstReady", alloc_ready, 1);
    chk("rstFull", full, 0);
    chk("rstTag", alloc_rob_num, 0);
    chk("rstRetV", retire_valid, 0);
    chk("rstFreeV", free_valid, 0);
    rst = 0;

    // 2: single alloc, complete, retire two edges after completion edge
    doReset();
    alloc(1, 5'd3, 6'd33, 6'd3); tick();
    chk("t2Count", count, 1);
    idle(); cmpl(4'd0); tick();
    idle();
    chk("t2RetE", retire_valid, 0);
    tick();
    chk("t2RetE1", retire_valid, 0);
    tick();
    chk("t2RetV", retire_valid, 1);
    chk("t2RetTag", retire_rob_num, 0);
    chk("t2RetDr", retire_dr, 3);
    chk("t2RetDrP", retire_dr_p, 33);
    chk("t2FreeV", free_valid, 1);
    chk("t2FreeP", free_p, 3);
    chk("t2Count0", count, 0);
    tick();
    chk("t2RetOff", retire_valid, 0);
    chk("t2FreeOff", free_valid, 0);
    chk("t2DrHold", retire_dr, 3);

    // 3: out-of-order completion, in-order retire
    doReset();
    for (int i = 0; i < 3; i++) begin
      alloc(1, 5'(i + 10), 6'(i + 20), 6'(i + 1)); tick();
    end
    idle(); cmpl(4'd2); tick();
    cmpl(4'd1); tick();
    chk("t3Hold", retire_valid, 0);
    cmpl(4'd0); tick();
    idle(); tick();
    chk("t3E1", retire_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3RetV", retire_valid, 1);
      chk("t3RetTag", retire_rob_num, i);
      chk("t3RetDr", retire_dr, i + 10);
      chk("t3FreeP", free_p, i + 1);
    end
    tick();
    chk("t3Done", retire_valid, 0);

    // 4: fill, overflow attempt ignored, retire frees a slot, tag wraps
    doReset();
    for (int i = 0; i < 16; i++) begin
      alloc(1, 5'(i + 1), 6'(i + 40), 6'(i + 1)); tick();
    end
    chk("t4Full", full, 1);
    chk("t4Ready", alloc_ready, 0);
    chk("t4Count", count, 16);
    chk("t4Empty", empty, 0);
    alloc(1, 5'd31, 6'd63, 6'd9); tick();
    chk("t4Over", count, 16);
    idle(); cmpl(4'd0); tick();
    chk("t4StillFull", alloc_ready, 0);
    idle(); tick();
    chk("t4Count15", count, 15);
    chk("t4ReadyAgain", alloc_ready, 1);
    chk("t4Wrap", alloc_rob_num, 0);
    tick();
    chk("t4RetV", retire_valid, 1);
    chk("t4RetDr", retire_dr, 1);
    chk("t4RetDrP", retire_dr_p, 40);

    // 5: no free for old_p==0 or regwrite==0
    doReset();
    alloc(1, 5'd5, 6'd40, 6'd0); tick();
    alloc(0, 5'd6, 6'd41, 6'd7); tick();
    idle(); cmpl(4'd0); tick();
    cmpl(4'd1); tick();
    idle(); tick();
    chk("t5RetV0", retire_valid, 1);
    chk("t5Dr0", retire_dr, 5);
    chk("t5FreeV0", free_valid, 0);
    tick();
    chk("t5RetV1", retire_valid, 1);
    chk("t5Dr1", retire_dr, 6);
    chk("t5FreeV1", free_valid, 0);

    // 6: steady alloc+retire every cycle, then reset mid-stream
    doReset();
    retCnt = 0;
    for (int i = 0; i < 40; i++) begin
      alloc(1, 5'(i % 32), 6'(i % 64), 6'((i % 63) + 1));
      if (i > 0) cmpl(4'((i - 1) % 16));
      tick();
      if (i >= 2) chk("t6Count", count, 2);
      chk("t6Ready", alloc_ready, 1);
    end
    idle(); rst = 1; tick();
    chk("t6RstCount", count, 0);
    chk("t6RstEmpty", empty, 1);
    chk("t6RstRetV", retire_valid, 0);
    chk("t6RstFreeV", free_valid, 0);
    rst = 0; tick();
    chk("t6PostRet1", retire_valid, 0);
    tick();
    chk("t6PostRet2", retire_valid, 0);
    chk("t6RetCnt", retCnt, 37);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
